// File: rtl/stream_pack.sv
// stream_pack: LZS encode-side bit-stream packer.
//
// Concatenates variable-width codes (1..13 bits, right-justified) MSB-first
// into 16-bit words and hands each word downstream over valid/ready. A flush
// pads the last partial word with zeros, and done pulses once the block is
// closed.
//
// Ports:
//   clk         single clock
//   rst         asynchronous, active-high reset
//   code_data   code bits, right-justified; bits above the width are masked
//   code_width  valid bit count; 0 is a no-op, 14/15 are treated as 13
//   code_valid  a code is presented
//   code_ready  the code is accepted on this edge
//   flush       single-cycle request to drain the accumulator and end the block
//   out_data    packed word, first packed bit in bit 15
//   out_valid   out_data holds a word
//   out_ready   downstream takes the word on this edge
//   busy        accumulator non-empty or flush in progress
//   done        one-cycle pulse after the last flushed word is taken
module stream_pack (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] code_data,
   input  logic [3:0]  code_width,
   input  logic        code_valid,
   output logic        code_ready,
   input  logic        flush,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_RUN   = 2'b00,
      S_FLUSH = 2'b01,
      S_DONE  = 2'b11
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] sreg_q, sreg_d;   // valid bits left-aligned at bit 31
   logic [5:0]  cnt_q, cnt_d;     // number of valid bits, 0..32

   logic        emit;
   logic        accept;
   logic [5:0]  width;
   logic [5:0]  bcnt;
   logic [5:0]  shamt;
   logic [31:0] base;
   logic [31:0] code_ext;

   // Widths above 13 saturate to the code width.
   function automatic logic [5:0] eff_width(input logic [3:0] w);
      return (w > 4'd13) ? 6'd13 : {2'b00, w};
   endfunction

   function automatic logic [12:0] code_mask(input logic [5:0] w);
      logic [13:0] m;
      m = (14'd1 << w) - 14'd1;
      return m[12:0];
   endfunction

   assign code_ready = (state_q == S_RUN) && (cnt_q <= 6'd19);
   assign out_valid  = (cnt_q >= 6'd16) || ((state_q == S_FLUSH) && (cnt_q != 6'd0));
   assign out_data   = sreg_q[31:16];
   assign busy       = (cnt_q != 6'd0) || (state_q != S_RUN);
   assign done       = (state_q == S_DONE);

   always_comb begin
      emit     = out_valid && out_ready;
      accept   = code_valid && code_ready;
      width    = eff_width(code_width);
      code_ext = {19'd0, code_data & code_mask(width)};

      // A word leaving shifts the accumulator up; a padded partial word
      // (fewer than 16 bits, only possible while flushing) empties it.
      base = sreg_q;
      bcnt = cnt_q;
      if (emit) begin
         base = sreg_q << 16;
         bcnt = (cnt_q >= 6'd16) ? (cnt_q - 6'd16) : 6'd0;
      end

      // bcnt + width never exceeds 32 here, so shamt stays in 0..32;
      // a shift of 32 only occurs for a zero-width code and yields zero.
      shamt  = 6'd32 - bcnt - width;
      sreg_d = base;
      cnt_d  = bcnt;
      if (accept) begin
         sreg_d = base | (code_ext << shamt);
         cnt_d  = bcnt + width;
      end

      state_d = state_q;
      case (state_q)
         S_RUN: begin
            // A code in the same cycle as flush is absorbed above first.
            if (flush) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (cnt_d == 6'd0) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_RUN;
            sreg_d  = 32'd0;
            cnt_d   = 6'd0;
         end
         default: begin
            state_d = S_RUN;
            sreg_d  = 32'd0;
            cnt_d   = 6'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RUN;
         sreg_q  <= 32'd0;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_stream_pack.sv
// Directed bench for stream_pack: drives hand-built code sequences and
// compares handshakes, held words and the collected word stream against
// hand-computed values.
module tb_stream_pack;

   logic        clk;
   logic        rst;
   logic [12:0] code_data;
   logic [3:0]  code_width;
   logic        code_valid;
   logic        code_ready;
   logic        flush;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   logic [15:0] words[$];
   logic [15:0] exp_words[7] = '{16'h2090, 16'h8000, 16'hFFFF, 16'hFFFF,
                                 16'hFE00, 16'h5AAA, 16'hFFF8};

   stream_pack dut (
      .clk        (clk),
      .rst        (rst),
      .code_data  (code_data),
      .code_width (code_width),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .flush      (flush),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs only change 1 ns after a rising edge, so a handshake seen at
   // the falling edge is the one taken at the next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) words.push_back(out_data);
         if (done) done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [12:0] d, input logic [3:0] w);
      code_valid = 1'b1;
      code_data  = d;
      code_width = w;
      step();
      code_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with a code pending
      rst        = 1'b1;
      code_valid = 1'b1;
      code_data  = 13'h1FFF;
      code_width = 4'd13;
      flush      = 1'b0;
      out_ready  = 1'b1;
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_code_ready", code_ready, 1);
      step();
      step();
      code_valid = 1'b0;
      rst        = 1'b0;
      step();
      step();
      step();
      chk("post_rst_words", words.size(), 0);
      chk("post_rst_busy", busy, 0);

      // Two 9-bit literals, then flush of the 2 leftover bits
      push(13'h041, 4'd9);
      push(13'h042, 4'd9);
      chk("lit_valid", out_valid, 1);
      chk("lit_word", out_data, 16'h2090);
      step();
      chk("lit_cnt", dut.cnt_q, 2);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("lit_pad_valid", out_valid, 1);
      chk("lit_pad_word", out_data, 16'h8000);
      step();
      chk("lit_done", done, 1);
      step();
      chk("lit_done_low", done, 0);
      chk("lit_idle", busy, 0);

      // Backpressure
      out_ready = 1'b0;
      push(13'h1FFF, 4'd13);
      push(13'h1FFF, 4'd13);
      chk("bp_ready_low", code_ready, 0);
      chk("bp_word", out_data, 16'hFFFF);
      code_valid = 1'b1;
      code_data  = 13'h1FFF;
      code_width = 4'd13;
      step();
      chk("bp_hold_word", out_data, 16'hFFFF);
      chk("bp_hold_cnt", dut.cnt_q, 26);
      out_ready = 1'b1;
      step();
      chk("bp_ready_back", code_ready, 1);
      chk("bp_cnt_after_take", dut.cnt_q, 10);
      out_ready = 1'b0;
      step();
      code_valid = 1'b0;
      chk("bp_third_accepted", dut.cnt_q, 23);
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      flush = 1'b0;
      chk("bp_pad_word", out_data, 16'hFE00);
      step();
      chk("bp_done", done, 1);
      step();

      // Masking, zero-width no-op, flush together with the last code
      push(13'h1FF5, 4'd4);
      push(13'h0AAA, 4'd0);
      chk("mask_cnt", dut.cnt_q, 4);
      code_valid = 1'b1;
      code_data  = 13'h0AAA;
      code_width = 4'd12;
      flush      = 1'b1;
      step();
      code_valid = 1'b0;
      flush      = 1'b0;
      chk("mask_cnt16", dut.cnt_q, 16);
      chk("mask_word", out_data, 16'h5AAA);
      step();
      chk("mask_done", done, 1);
      step();

      // Width 15 saturates to 13
      push(13'h1FFF, 4'd15);
      chk("w15_cnt", dut.cnt_q, 13);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("w15_word", out_data, 16'hFFF8);
      step();
      chk("w15_done", done, 1);
      step();

      // Empty flush
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("empty_valid", out_valid, 0);
      chk("empty_done_early", done, 0);
      chk("empty_busy", busy, 1);
      step();
      chk("empty_done", done, 1);
      step();
      chk("empty_done_low", done, 0);

      // Reset while flushing with the word held
      out_ready = 1'b0;
      push(13'h1FF, 4'd9);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("rflush_valid", out_valid, 1);
      chk("rflush_word", out_data, 16'hFF80);
      #2;
      rst = 1'b1;
      #1;
      chk("rflush_valid_drop", out_valid, 0);
      chk("rflush_busy", busy, 0);
      chk("rflush_ready", code_ready, 1);
      chk("rflush_state", dut.state_q, 0);
      step();
      step();
      rst = 1'b0;
      step();
      step();
      chk("rflush_no_done", done, 0);

      // Collected stream
      chk("done_pulses", done_cnt, 5);
      chk("word_count", words.size(), 7);
      for (int i = 0; i < 7; i++) begin
         if (i < words.size()) chk($sformatf("word%0d", i), words[i], exp_words[i]);
         else chk($sformatf("word%0d_missing", i), 32'hDEAD, exp_words[i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
